// File: rtl/cpu_cpu_div_pkg.sv
// Shared types and constants for the iterative radix-2 divider cell.
package cpu_cpu_div_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DIV_ITERS   = 32;
    localparam int unsigned DIV_LATENCY = 35;
    localparam int unsigned CNT_W       = $clog2(DIV_ITERS);

    localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/cpu_cpu_div_cell_if.sv
// Request/response bundle between the A-stage pipeline and the divider cell.
interface cpu_cpu_div_cell_if;
    import cpu_cpu_div_pkg::*;

    logic              A_div_start;
    logic [DATA_W-1:0] A_div_src1;
    logic [DATA_W-1:0] A_div_src2;
    logic              A_div_signed;
    logic              A_div_rem_sel;
    logic              A_div_busy;
    logic              A_div_done;
    logic [DATA_W-1:0] A_div_cell_result;

    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed, A_div_rem_sel,
        input  A_div_busy, A_div_done, A_div_cell_result
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed, A_div_rem_sel,
        output A_div_busy, A_div_done, A_div_cell_result
    );
endinterface

// File: rtl/cpu_cpu_div_step.sv
// One restoring-division iteration: shift dividend MSB into the remainder and trial-subtract.
module cpu_cpu_div_step
    import cpu_cpu_div_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] shift,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] shift_next,
    output logic              q_bit
);

    logic [DATA_W:0] rem_sh;

    // The kept remainder is always below the divisor, so it fits back into DATA_W bits.
    always_comb begin
        rem_sh     = {rem, shift[DATA_W-1]};
        q_bit      = (rem_sh >= {1'b0, divisor});
        rem_next   = q_bit ? DATA_W'(rem_sh - {1'b0, divisor}) : rem_sh[DATA_W-1:0];
        shift_next = {shift[DATA_W-2:0], 1'b0};
    end

endmodule

// File: rtl/cpu_cpu_div_cell.sv
// Iterative 32-bit divider: fixed 35-cycle latency, signed/unsigned, quotient or remainder.
module cpu_cpu_div_cell
    import cpu_cpu_div_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    cpu_cpu_div_cell_if.slave  div
);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dsr;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] src1_orig;
    logic              is_signed;
    logic              rem_sel;
    logic              q_neg;
    logic              r_neg;
    logic              div0;

    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_shift;
    logic              step_q;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    cpu_cpu_div_step u_step (
        .rem        (rem),
        .shift      (dvd),
        .divisor    (dsr),
        .rem_next   (step_rem),
        .shift_next (step_shift),
        .q_bit      (step_q)
    );

    // Sign restoration and the divide-by-zero override applied in FIX.
    always_comb begin
        quot_fix = q_neg ? DATA_W'(-dvd) : dvd;
        rem_fix  = r_neg ? DATA_W'(-rem) : rem;
        if (div0) begin
            quot_fix = DIV0_QUOT;
            rem_fix  = src1_orig;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            dvd                   <= '0;
            dsr                   <= '0;
            rem                   <= '0;
            src1_orig             <= '0;
            is_signed             <= 1'b0;
            rem_sel               <= 1'b0;
            q_neg                 <= 1'b0;
            r_neg                 <= 1'b0;
            div0                  <= 1'b0;
            div.A_div_busy        <= 1'b0;
            div.A_div_done        <= 1'b0;
            div.A_div_cell_result <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (div.A_div_start) begin
                        dvd            <= div.A_div_src1;
                        dsr            <= div.A_div_src2;
                        src1_orig      <= div.A_div_src1;
                        is_signed      <= div.A_div_signed;
                        rem_sel        <= div.A_div_rem_sel;
                        div.A_div_busy <= 1'b1;
                        state          <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (is_signed) begin
                        dvd   <= abs_val(dvd);
                        dsr   <= abs_val(dsr);
                        q_neg <= dvd[DATA_W-1] ^ dsr[DATA_W-1];
                        r_neg <= dvd[DATA_W-1];
                    end else begin
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end
                    div0  <= (dsr == '0);
                    rem   <= '0;
                    cnt   <= CNT_W'(DIV_ITERS - 1);
                    state <= S_ITER;
                end
                S_ITER: begin
                    // The freed LSB of the dividend shift register collects quotient bits.
                    rem <= step_rem;
                    dvd <= step_shift | DATA_W'(step_q);
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    div.A_div_cell_result <= rem_sel ? rem_fix : quot_fix;
                    div.A_div_done        <= 1'b1;
                    state                 <= S_DONE;
                end
                S_DONE: begin
                    div.A_div_done <= 1'b0;
                    div.A_div_busy <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_cpu_div_cell.sv
// Randomized self-checking bench for cpu_cpu_div_cell against an arithmetic reference model.
module tb_cpu_cpu_div_cell;
    import cpu_cpu_div_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_cpu_div_cell_if bus ();

    cpu_cpu_div_cell dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Truncating division, remainder takes the dividend's sign; fixed results for /0 and overflow.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rs);
        int sa;
        int sb;
        if (b == 32'd0) return rs ? a : 32'hFFFF_FFFF;
        if (!sgn) return rs ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rs ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return rs ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, input logic rs);
        bus.A_div_start   = 1'b1;
        bus.A_div_src1    = a;
        bus.A_div_src2    = b;
        bus.A_div_signed  = sgn;
        bus.A_div_rem_sel = rs;
    endtask

    task automatic scramble_inputs();
        bus.A_div_start   = 1'b0;
        bus.A_div_src1    = $urandom;
        bus.A_div_src2    = $urandom;
        bus.A_div_signed  = 1'($urandom);
        bus.A_div_rem_sel = 1'($urandom);
    endtask

    // One full operation; optional extra start pulses at cycles 5 and 20 must be ignored.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic rs, input bit inj);
        logic [31:0] exp;
        logic [31:0] res_at_done;
        int          first;
        int          ndone;
        exp         = ref_div(a, b, sgn, rs);
        res_at_done = 32'hDEAD_BEEF;
        first       = 0;
        ndone       = 0;
        @(negedge clk);
        drive_start(a, b, sgn, rs);
        @(negedge clk);
        scramble_inputs();
        check({tag, "_busy1"}, 32'(bus.A_div_busy), 32'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.A_div_done) begin
                ndone++;
                if (first == 0) begin
                    first       = cyc;
                    res_at_done = bus.A_div_cell_result;
                end
            end
            if (inj && (cyc == 5 || cyc == 20)) begin
                drive_start($urandom, $urandom, 1'($urandom), 1'($urandom));
            end else begin
                bus.A_div_start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(first), 32'(DIV_LATENCY));
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        check({tag, "_res"}, res_at_done, exp);
        check({tag, "_hold"}, bus.A_div_cell_result, exp);
        check({tag, "_idle"}, 32'(bus.A_div_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          ndone;

        reset_n = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.A_div_busy), 32'd0);
        check("rst_done", 32'(bus.A_div_done), 32'd0);
        check("rst_res", bus.A_div_cell_result, 32'd0);
        reset_n = 1'b1;

        do_op("u100d7_q", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        do_op("u100d7_r", 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        do_op("sm100d7_q", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 1'b0);
        do_op("sm100d7_r", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 1'b0);
        do_op("s100dm7_q", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
        do_op("s100dm7_r", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 1'b0);
        do_op("u_div0_q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
        do_op("u_div0_r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
        do_op("s_div0_q", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op("s_div0_r", 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b0);
        do_op("s_negdiv0_r", 32'h8765_4321, 32'd0, 1'b1, 1'b1, 1'b0);
        do_op("s_ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        do_op("s_ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op("u_max_d1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        do_op("u_max_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        do_op("inj_start", 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation discards it and suppresses done.
        @(negedge clk);
        drive_start(32'd1000, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        scramble_inputs();
        for (int cyc = 1; cyc < 17; cyc++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.A_div_busy), 32'd0);
        check("midrst_done", 32'(bus.A_div_done), 32'd0);
        check("midrst_res", bus.A_div_cell_result, 32'd0);
        reset_n = 1'b1;
        ndone   = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (bus.A_div_done) ndone++;
            @(negedge clk);
        end
        check("midrst_nodone", 32'(ndone), 32'd0);
        do_op("post_rst", 32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = $urandom & 32'h0000_FFFF;
                2:       rb = 32'(-$signed(32'($urandom_range(1, 300))));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 19) == 0) rb = 32'd0;
            do_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
